// File: rtl/wb_periph_split_pkg.sv
// Shared types and helpers for the Wishbone peripheral splitter.
package wb_periph_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int unsigned DAT_W     = 32;
  localparam int unsigned MAX_NS    = 16;
  localparam int unsigned IDX_MAX_W = 4;
  localparam int unsigned DAT_ALL_W = MAX_NS * DAT_W;

  localparam logic [DAT_W-1:0] BAD_DATA_DEF = 32'hDEAD_BEEF;

  // Picks one slave's read word out of the flattened (zero-extended) data bus.
  function automatic logic [DAT_W-1:0] slave_dat(input logic [DAT_ALL_W-1:0] dat_all,
                                                 input logic [IDX_MAX_W-1:0] idx);
    return dat_all[DAT_W*idx +: DAT_W];
  endfunction

endpackage

// File: rtl/wb_periph_split_wdog.sv
// Per-transaction watchdog: stall counter, expiry detect, sticky timeout flag and index.
// Only instantiated when WB_PERIPH_SPLIT_TIMEOUT_EN is defined.
module wb_periph_split_wdog
  import wb_periph_split_pkg::*;
#(
  parameter int unsigned TMO_W = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             clr_i,
  output logic             expire_c,
  output logic             tmo_irq_o,
  output logic [IDX_W-1:0] tmo_idx_o
);

  localparam logic [TMO_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] CNT_LAST = CNT_MAX - TMO_W'(1);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic [IDX_W-1:0] tidx_q, tidx_d;

  // The count reaching CNT_MAX is the timeout; it is detected on the
  // increment so the access completes on the same edge the counter saturates.
  always_comb begin
    cnt_d    = '0;
    expire_c = 1'b0;
    irq_d    = irq_q;
    tidx_d   = tidx_q;
    if (run_i) begin
      cnt_d    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + TMO_W'(1);
      expire_c = (cnt_q == CNT_LAST) || (cnt_q == CNT_MAX);
    end
    // A new timeout outranks a clear arriving in the same cycle.
    if (expire_c) begin
      irq_d  = 1'b1;
      tidx_d = idx_i;
    end else if (clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      irq_q  <= 1'b0;
      tidx_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
      tidx_q <= tidx_d;
    end
  end

  assign tmo_irq_o = irq_q;
  assign tmo_idx_o = tidx_q;

endmodule

// File: rtl/wb_periph_split.sv
// Wishbone classic splitter: decodes an address field into one-hot slave strobes,
// registers the response path and answers unmapped accesses with BAD_DATA.
// Optional watchdog enabled by defining WB_PERIPH_SPLIT_TIMEOUT_EN.
module wb_periph_split
  import wb_periph_split_pkg::*;
#(
  parameter int unsigned      NS       = 4,
  parameter int unsigned      SEL_LSB  = 16,
  parameter int unsigned      SEL_W    = 4,
  parameter int unsigned      TMO_W    = 8,
  parameter logic [DAT_W-1:0] BAD_DATA = BAD_DATA_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               s_cyc_o,
  output logic [NS-1:0]      s_stb_o,
  input  logic [NS-1:0]      s_ack_i,
  input  logic [NS*32-1:0]   s_dat_i,
  input  logic               tmo_clr_i,
  output logic               tmo_irq_o,
  output logic [SEL_W-1:0]   tmo_idx_o
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               ack_q, ack_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic [NS-1:0]      stb_q, stb_d;

  logic               req_c;
  logic               mapped_c;
  logic               ack_hit_c;
  logic               expire_c;
  logic [SEL_W-1:0]   sel_field_c;

  assign req_c       = wbs_cyc_i & wbs_stb_i;
  assign sel_field_c = wbs_adr_i[SEL_LSB +: SEL_W];
  assign mapped_c    = 32'(sel_field_c) < NS;
  // The registered strobe is already one-hot on idx while ACTIVE, so masking
  // with it discards acks from unselected slaves and acks outside ACTIVE.
  assign ack_hit_c   = (state_q == ST_ACTIVE) && |(s_ack_i & stb_q);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_c) state_d = mapped_c ? ST_ACTIVE : ST_RESP;
      end
      ST_ACTIVE: begin
        // Master abort takes priority over a late slave ack or expiry.
        if (!wbs_cyc_i)                 state_d = ST_IDLE;
        else if (ack_hit_c || expire_c) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they appear registered in that state.
  always_comb begin
    idx_d = idx_q;
    ack_d = 1'b0;
    dat_d = dat_q;
    stb_d = '0;
    if (state_q == ST_IDLE && req_c) idx_d = sel_field_c;
    if (state_d == ST_ACTIVE) stb_d = NS'(1) << idx_d;
    if (state_d == ST_RESP) begin
      ack_d = 1'b1;
      dat_d = ack_hit_c ? slave_dat(DAT_ALL_W'(s_dat_i), IDX_MAX_W'(idx_q)) : BAD_DATA;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      idx_q <= '0;
      ack_q <= 1'b0;
      dat_q <= '0;
      stb_q <= '0;
    end else begin
      idx_q <= idx_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
      stb_q <= stb_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign s_stb_o   = stb_q;
  assign s_cyc_o   = wbs_cyc_i;

`ifdef WB_PERIPH_SPLIT_TIMEOUT_EN
  wb_periph_split_wdog #(
    .TMO_W (TMO_W),
    .IDX_W (SEL_W)
  ) u_wdog (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .run_i     ((state_q == ST_ACTIVE) && wbs_cyc_i && !ack_hit_c),
    .idx_i     (idx_q),
    .clr_i     (tmo_clr_i),
    .expire_c  (expire_c),
    .tmo_irq_o (tmo_irq_o),
    .tmo_idx_o (tmo_idx_o)
  );
`else
  logic unused_tmo;
  assign expire_c   = 1'b0;
  assign tmo_irq_o  = 1'b0;
  assign tmo_idx_o  = '0;
  assign unused_tmo = tmo_clr_i ^ (TMO_W == 0);
`endif

  // Bus fields the slaves take directly from the master.
  logic unused_bus;
  assign unused_bus = ^{wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i};

endmodule

// File: tb/tb_wb_periph_split.sv
// Directed self-checking bench for wb_periph_split (NS=4, TMO_W=4).
// Timeout cases run only when WB_PERIPH_SPLIT_TIMEOUT_EN is defined.
module tb_wb_periph_split;

  localparam int unsigned NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat;
  logic          ack_o;
  logic [31:0]   dat_o;
  logic          s_cyc;
  logic [NS-1:0] s_stb;
  logic [NS-1:0] s_ack;
  logic [NS*32-1:0] s_dat;
  logic          tmo_clr;
  logic          tmo_irq;
  logic [3:0]    tmo_idx;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wb_periph_split #(
    .NS      (NS),
    .SEL_LSB (16),
    .SEL_W   (4),
    .TMO_W   (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack_o),
    .wbs_dat_o (dat_o),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_ack_i   (s_ack),
    .s_dat_i   (s_dat),
    .tmo_clr_i (tmo_clr),
    .tmo_irq_o (tmo_irq),
    .tmo_idx_o (tmo_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [31:0] a, input logic w);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a;
    tick();
  endtask

  task automatic end_req();
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic [31:0] v);
    s_dat[32*i +: 32] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
    adr = '0; wdat = 32'hCAFE_F00D; s_ack = '0; s_dat = '0; tmo_clr = 1'b0;
    for (int i = 0; i < 4; i++) set_slot(i, 32'hA000_0000 | 32'(i));
    tick(); tick();
    check_eq("rst_ack", 32'(ack_o), 0);
    check_eq("rst_dat", dat_o, 0);
    check_eq("rst_stb", 32'(s_stb), 0);
    check_eq("rst_irq", 32'(tmo_irq), 0);
    check_eq("rst_idx", 32'(tmo_idx), 0);
    rst = 1'b0;
    tick();

    // Read slave 2, slave acks in the fourth strobe cycle.
    set_slot(2, 32'h1234_5678);
    start_req(32'h0002_0010, 1'b0);
    check_eq("rd_cyc", 32'(s_cyc), 1);
    for (int c = 1; c <= 3; c++) begin
      check_eq("rd_stb", 32'(s_stb), 32'h4);
      check_eq("rd_noack", 32'(ack_o), 0);
      tick();
    end
    s_ack = 4'b0100;
    check_eq("rd_stb_ack", 32'(s_stb), 32'h4);
    tick();
    check_eq("rd_ack", 32'(ack_o), 1);
    check_eq("rd_dat", dat_o, 32'h1234_5678);
    check_eq("rd_stb_off", 32'(s_stb), 0);
    s_ack = '0; end_req();
    tick();
    check_eq("rd_ack_once", 32'(ack_o), 0);
    check_eq("rd_dat_hold", dat_o, 32'h1234_5678);

    // Unmapped write (field 5) and first unmapped field (4).
    start_req(32'h0005_0000, 1'b1);
    check_eq("um5_ack", 32'(ack_o), 1);
    check_eq("um5_dat", dat_o, 32'hDEAD_BEEF);
    check_eq("um5_stb", 32'(s_stb), 0);
    end_req();
    tick();
    check_eq("um5_ack_once", 32'(ack_o), 0);
    start_req(32'h0004_0000, 1'b0);
    check_eq("um4_ack", 32'(ack_o), 1);
    check_eq("um4_stb", 32'(s_stb), 0);
    end_req();
    tick();

    // Back-to-back slave 0 then slave 3 with a stray ack from slave 1.
    set_slot(0, 32'h0000_00A0);
    set_slot(1, 32'hBAD0_0001);
    set_slot(3, 32'h3333_0003);
    s_ack = 4'b0010;
    start_req(32'h0000_0000, 1'b0);
    check_eq("b2b0_stb", 32'(s_stb), 32'h1);
    check_eq("b2b0_stray", 32'(ack_o), 0);
    s_ack = 4'b0011;
    tick();
    check_eq("b2b0_ack", 32'(ack_o), 1);
    check_eq("b2b0_dat", dat_o, 32'h0000_00A0);
    adr = 32'h0003_0000; s_ack = 4'b0010;
    tick();
    check_eq("b2b_gap_ack", 32'(ack_o), 0);
    check_eq("b2b_gap_stb", 32'(s_stb), 0);
    tick();
    check_eq("b2b3_stb", 32'(s_stb), 32'h8);
    check_eq("b2b3_stray", 32'(ack_o), 0);
    s_ack = 4'b1010;
    tick();
    check_eq("b2b3_ack", 32'(ack_o), 1);
    check_eq("b2b3_dat", dat_o, 32'h3333_0003);
    end_req(); s_ack = '0;
    tick();
    check_eq("b2b3_ack_once", 32'(ack_o), 0);

    // Master abort in ACTIVE, then a late slave ack must be ignored.
    start_req(32'h0001_0000, 1'b0);
    tick();
    check_eq("abt_stb", 32'(s_stb), 32'h2);
    end_req();
    tick();
    check_eq("abt_stb_off", 32'(s_stb), 0);
    check_eq("abt_noack", 32'(ack_o), 0);
    s_ack = 4'b0010;
    tick();
    check_eq("abt_late_ack", 32'(ack_o), 0);
    s_ack = '0;
    tick();

`ifdef WB_PERIPH_SPLIT_TIMEOUT_EN
    // Slave 1 never acks: ack arrives in cycle 16 with BAD_DATA.
    set_slot(1, 32'h5A5A_0001);
    start_req(32'h0001_0000, 1'b0);
    n = 1;
    while (ack_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_eq("tmo_lat", 32'(n), 16);
    check_eq("tmo_dat", dat_o, 32'hDEAD_BEEF);
    check_eq("tmo_irq", 32'(tmo_irq), 1);
    check_eq("tmo_idx", 32'(tmo_idx), 1);
    check_eq("tmo_stb", 32'(s_stb), 0);
    end_req();
    tick();
    check_eq("tmo_sticky", 32'(tmo_irq), 1);
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    check_eq("tmo_clr", 32'(tmo_irq), 0);
    check_eq("tmo_idx_hold", 32'(tmo_idx), 1);

    // Slave ack in the expiry cycle wins.
    start_req(32'h0001_0000, 1'b0);
    for (int c = 0; c < 14; c++) tick();
    check_eq("race_noack", 32'(ack_o), 0);
    s_ack = 4'b0010;
    tick();
    check_eq("race_ack", 32'(ack_o), 1);
    check_eq("race_dat", dat_o, 32'h5A5A_0001);
    check_eq("race_irq", 32'(tmo_irq), 0);
    s_ack = '0; end_req();
    tick();

    // Clear coincides with a new timeout on slave 3: set wins.
    start_req(32'h0003_0000, 1'b0);
    for (int c = 0; c < 14; c++) tick();
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    check_eq("setclr_ack", 32'(ack_o), 1);
    check_eq("setclr_irq", 32'(tmo_irq), 1);
    check_eq("setclr_idx", 32'(tmo_idx), 3);
    end_req();
    tick();
`else
    // Without the watchdog a silent slave stalls indefinitely.
    start_req(32'h0001_0000, 1'b0);
    for (int c = 0; c < 20; c++) tick();
    check_eq("nowd_noack", 32'(ack_o), 0);
    check_eq("nowd_stb", 32'(s_stb), 32'h2);
    check_eq("nowd_irq", 32'(tmo_irq), 0);
    end_req();
    tick();
`endif

    // Reset during an access with a pending slave ack.
    start_req(32'h0002_0000, 1'b0);
    check_eq("rsta_stb", 32'(s_stb), 32'h4);
    s_ack = 4'b0100; rst = 1'b1;
    tick();
    check_eq("rsta_stb_off", 32'(s_stb), 0);
    check_eq("rsta_noack", 32'(ack_o), 0);
    check_eq("rsta_dat", dat_o, 0);
    check_eq("rsta_irq", 32'(tmo_irq), 0);
    check_eq("rsta_idx", 32'(tmo_idx), 0);
    rst = 1'b0; s_ack = '0; end_req();
    tick();
    check_eq("rsta_after", 32'(ack_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
